sync_fifo: RTL and testbench

Synchronous single-clock FIFO: the design under test whose `fifo_interface` signals the FIFO monitor samples on every negative clock edge. It buffers `FIFO_WIDTH`-bit words between a write port and a read port. It reports a write acknowledge, overflow and underflow pulses, and full, empty, almost-full and almost-empty status flags.

---
 rtl/sync_fifo_pkg.sv | 6 +
 rtl/sync_fifo_if.sv | 30 +++
 rtl/sync_fifo_mem.sv | 23 ++
 rtl/sync_fifo.sv | 94 +++++++++
 tb/tb_sync_fifo.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing for the FIFO, its interface and any reference model.
package fifo_pkg;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_PTR_W      = $clog2(DEF_FIFO_DEPTH);
endpackage

// File: rtl/sync_fifo_if.sv
// FIFO port bundle: requests from the producer/consumer side, status back from the FIFO.
interface fifo_interface
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one combinational read port, contents not reset.
module sync_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, registered read data and handshake pulses.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_interface.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_AFULL = (PTR_W+1)'(FIFO_DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [PTR_W:0]        w_count_next;
    logic [FIFO_WIDTH-1:0] w_rdata;

    // Occupancy is tracked by count, so full and empty never depend on pointer equality.
    assign w_full      = (r_count == CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = bus.wr_en && !w_full;
    assign w_rd_accept = bus.rd_en && !w_empty;

    // A read on a full FIFO frees a slot even though the concurrent write is refused.
    always_comb begin
        w_count_next = r_count;
        if (w_wr_accept && !w_rd_accept) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_rd_accept && !w_wr_accept) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    sync_fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_wr_ack    <= w_wr_accept;
            r_overflow  <= bus.wr_en && w_full;
            r_underflow <= bus.rd_en && w_empty;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_data_out <= w_rdata;
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count == CNT_AFULL);
    assign bus.almostempty = (r_count == CNT_ONE);
endmodule

// File: tb/tb_sync_fifo.sv
// Table-driven bench for sync_fifo with a data scoreboard queue and hand-written reset sequence.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int W = DEF_FIFO_WIDTH;
    localparam int D = DEF_FIFO_DEPTH;

    typedef struct {
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        logic         ack;
        logic         ov;
        logic         un;
        int           cnt;
    } vec_t;

    logic clk;
    logic rst_n;

    fifo_interface #(.FIFO_WIDTH(W)) bus ();

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_vectors;
    int           n_miscompares;
    logic [W-1:0] sb_q [$];
    logic [W-1:0] exp_dout;
    vec_t         vecs [$];

    // Expected flag vector: {wr_ack, overflow, underflow, full, empty, almostfull, almostempty}
    function automatic logic [6:0] flags_of(logic ack, logic ov, logic un, int cnt);
        return {ack, ov, un, cnt == D, cnt == 0, cnt == D - 1, cnt == 1};
    endfunction

    function automatic logic [6:0] dut_flags();
        return {bus.wr_ack, bus.overflow, bus.underflow, bus.full, bus.empty,
                bus.almostfull, bus.almostempty};
    endfunction

    function automatic void add(logic wr, logic rd, logic [W-1:0] din,
                                logic ack, logic ov, logic un, int cnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.ack = ack; v.ov = ov; v.un = un; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [6:0] exp_f, logic [W-1:0] exp_d);
        logic [6:0] got_f;
        got_f = dut_flags();
        n_vectors++;
        if (got_f !== exp_f || bus.data_out !== exp_d) begin
            n_miscompares++;
            $display("FAIL %s: flags=%b data_out=%h, required flags=%b data_out=%h",
                     name, got_f, bus.data_out, exp_f, exp_d);
        end else begin
            $display("ok   %s: flags=%b data_out=%h", name, got_f, bus.data_out);
        end
    endtask

    task automatic apply(string name, vec_t v);
        bus.wr_en   = v.wr;
        bus.rd_en   = v.rd;
        bus.data_in = v.din;
        @(posedge clk);
        #1;
        if (v.rd && !v.un) begin
            if (sb_q.size() == 0) begin
                n_miscompares++;
                $display("FAIL %s: scoreboard empty on expected read, required a queued word", name);
            end else begin
                exp_dout = sb_q.pop_front();
            end
        end
        if (v.ack) sb_q.push_back(v.din);
        check(name, flags_of(v.ack, v.ov, v.un, v.cnt), exp_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        n_vectors     = 0;
        n_miscompares = 0;
        exp_dout      = '0;

        // Underflow on empty, then fill past full, then drain
        add(0, 1, 16'h0000, 0, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 0);
        for (int i = 1; i <= D; i++) add(1, 0, W'(i), 1, 0, 0, i);
        add(1, 0, 16'h0009, 0, 1, 0, D);
        add(1, 1, 16'h0077, 0, 1, 0, D - 1);
        for (int k = D - 2; k >= 0; k--) add(0, 1, 16'h0000, 0, 0, 0, k);
        // Simultaneous on empty, then read it back, then underflow holding data_out
        add(1, 1, 16'hABCD, 1, 0, 1, 1);
        add(0, 1, 16'h0000, 0, 0, 0, 0);
        add(0, 1, 16'h0000, 0, 0, 1, 0);
        // Wrap-around at count 3
        for (int j = 1; j <= 3; j++) add(1, 0, W'(16'h0100 + j), 1, 0, 0, j);
        for (int j = 0; j < 20; j++) add(1, 1, W'(16'h0200 + j), 1, 0, 0, 3);
        for (int j = 2; j >= 0; j--) add(0, 1, 16'h0000, 0, 0, 0, j);

        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset", flags_of(0, 0, 0, 0), '0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset with five words stored
        for (int i = 1; i <= 5; i++) begin
            v.wr = 1; v.rd = 0; v.din = W'(16'h0300 + i); v.ack = 1; v.ov = 0; v.un = 0; v.cnt = i;
            apply($sformatf("prefill%0d", i), v);
        end
        bus.wr_en   = 1'b1;
        bus.data_in = 16'h0399;
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_dout = '0;
        check("async_reset", flags_of(0, 0, 0, 0), '0);
        @(posedge clk);
        #1;
        check("held_reset", flags_of(0, 0, 0, 0), '0);
        rst_n = 1'b1;

        v.wr = 0; v.rd = 1; v.din = '0; v.ack = 0; v.ov = 0; v.un = 1; v.cnt = 0;
        apply("post_reset_underflow", v);
        v.wr = 1; v.rd = 0; v.din = 16'h0055; v.ack = 1; v.ov = 0; v.un = 0; v.cnt = 1;
        apply("post_reset_write", v);
        v.wr = 0; v.rd = 1; v.din = '0; v.ack = 0; v.ov = 0; v.un = 0; v.cnt = 0;
        apply("post_reset_read", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
